// File: rtl/spi_flash_arbiter.sv
// Two-port read arbiter in front of one SPI flash word reader. Keeps a pending
// slot per port and a one-word last-read buffer that serves repeats locally.

module spi_flash_arbiter_port #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rstrb_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  hit_i,
    input  logic [31:0]           buf_data_i,
    input  logic                  done_i,
    input  logic [31:0]           flash_rdata_i,
    output logic                  pend_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           rdata_o
);
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rdata_q, rdata_d;

    // A strobe while already pending is dropped; done_i only fires while pending,
    // so capture and completion never collide.
    always_comb begin
        pend_d  = pend_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        if (rstrb_i && !pend_q) begin
            if (hit_i) begin
                rdata_d = buf_data_i;
            end else begin
                pend_d = 1'b1;
                addr_d = addr_i;
            end
        end
        if (done_i) begin
            rdata_d = flash_rdata_i;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_q  <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    assign pend_o  = pend_q;
    assign addr_o  = addr_q;
    assign rdata_o = rdata_q;
endmodule

module spi_flash_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int RR_MODE    = 0,
    parameter int BUF_EN     = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  p0_rstrb_i,
    input  logic [ADDR_WIDTH-1:0] p0_word_address_i,
    output logic [31:0]           p0_rdata_o,
    output logic                  p0_rbusy_o,
    input  logic                  p1_rstrb_i,
    input  logic [ADDR_WIDTH-1:0] p1_word_address_i,
    output logic [31:0]           p1_rdata_o,
    output logic                  p1_rbusy_o,
    output logic                  flash_rstrb_o,
    output logic [ADDR_WIDTH-1:0] flash_word_address_o,
    input  logic [31:0]           flash_rdata_i,
    input  logic                  flash_rbusy_i
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t state_q, state_d;

    logic [NUM_PORTS-1:0]                 rstrb, pend, hit, done;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr, lat_addr;
    logic [NUM_PORTS-1:0][31:0]           rdata;

    logic                  sel_q, sel_d;
    logic                  rr_q, rr_d;
    logic                  fstrb_q, fstrb_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic                  buf_vld_q, buf_vld_d;
    logic [ADDR_WIDTH-1:0] buf_tag_q, buf_tag_d;
    logic [31:0]           buf_data_q, buf_data_d;
    logic                  issue, complete, pick;

    assign rstrb    = {p1_rstrb_i, p0_rstrb_i};
    assign req_addr = {p1_word_address_i, p0_word_address_i};

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
            assign hit[g]  = (BUF_EN != 0) && buf_vld_q && (req_addr[g] == buf_tag_q);
            assign done[g] = complete && (sel_q == 1'(g));

            spi_flash_arbiter_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_port (
                .clk           (clk),
                .resetn        (resetn),
                .rstrb_i       (rstrb[g]),
                .addr_i        (req_addr[g]),
                .hit_i         (hit[g]),
                .buf_data_i    (buf_data_q),
                .done_i        (done[g]),
                .flash_rdata_i (flash_rdata_i),
                .pend_o        (pend[g]),
                .addr_o        (lat_addr[g]),
                .rdata_o       (rdata[g])
            );
        end
    endgenerate

    // Port 1 wins a tie unless round-robin, where the port not served last wins.
    always_comb begin
        pick = pend[1];
        if (pend[0] && pend[1]) begin
            pick = (RR_MODE != 0) ? rr_q : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            fstrb_q    <= 1'b0;
            faddr_q    <= '0;
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            fstrb_q    <= fstrb_d;
            faddr_q    <= faddr_d;
            buf_vld_q  <= buf_vld_d;
            buf_tag_q  <= buf_tag_d;
            buf_data_q <= buf_data_d;
        end
    end

    // flash_rbusy is ignored in START: the reader raises it only a cycle after
    // it samples the strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pend && !flash_rbusy_i) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (!flash_rbusy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue      = (state_q == IDLE) && |pend && !flash_rbusy_i;
        complete   = (state_q == WAIT) && !flash_rbusy_i;
        sel_d      = sel_q;
        rr_d       = rr_q;
        fstrb_d    = issue;
        faddr_d    = faddr_q;
        buf_vld_d  = buf_vld_q;
        buf_tag_d  = buf_tag_q;
        buf_data_d = buf_data_q;
        if (issue) begin
            sel_d   = pick;
            faddr_d = lat_addr[pick];
        end
        if (complete) begin
            buf_vld_d  = 1'b1;
            buf_tag_d  = faddr_q;
            buf_data_d = flash_rdata_i;
            rr_d       = ~sel_q;
        end
    end

    assign p0_rdata_o           = rdata[0];
    assign p1_rdata_o           = rdata[1];
    assign p0_rbusy_o           = pend[0];
    assign p1_rbusy_o           = pend[1];
    assign flash_rstrb_o        = fstrb_q;
    assign flash_word_address_o = faddr_q;
endmodule
